// File: rtl/lagarto_fpu_pkg.sv
// Shared FPU definitions used by the mantissa divider.
//   div_state_t    : divider FSM encoding (idle, iterating, result presented)
//   div_iter_count : number of quotient bits produced for a given mantissa width
package lagarto_fpu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  // Integer bit, MANTISSA-1 fraction bits, guard and round.
  function automatic int div_iter_count(input int mantissa);
    return mantissa + 2;
  endfunction

endpackage

// File: rtl/lagarto_fp_div_step.sv
// One radix-2 restoring division step.
//   rem_i   : current partial remainder (always < 2*b_i)
//   b_i     : divisor mantissa
//   q_bit_o : quotient bit for this step (1 when rem_i >= b_i)
//   rem_o   : next partial remainder, already shifted left by one
module lagarto_fp_div_step #(
  parameter int MANTISSA = 53
) (
  input  logic [MANTISSA:0]   rem_i,
  input  logic [MANTISSA-1:0] b_i,
  output logic                q_bit_o,
  output logic [MANTISSA:0]   rem_o
);

  // One extra bit so the sign of the trial subtraction is visible.
  logic [MANTISSA+1:0] diff;

  // NOTE: combinational outputs are assigned on every path so no latch is inferred.
  always_comb begin
    diff    = {1'b0, rem_i} - {2'b00, b_i};
    q_bit_o = ~diff[MANTISSA+1];
    // The dropped top bit is zero because rem < 2b is invariant.
    rem_o   = q_bit_o ? (diff[MANTISSA:0] << 1) : (rem_i << 1);
  end

endmodule

// File: rtl/lagarto_fp_mantissa_div.sv
// Iterative radix-2 restoring divider for normalized FP mantissas.
// Produces Q = floor(a * 2^(MANTISSA+1) / b) (MANTISSA+2 bits) and a sticky bit.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   lock_i             : pipeline stall, freezes all state
//   flush_i            : kills the in-flight operation
//   op_valid_i/ready_o : request handshake (accepted when both high)
//   src1_i, src2_i     : dividend a, divisor b
//   result_valid_o     : result presented (one DONE cycle, longer if locked)
//   result_data_o      : quotient Q
//   sticky_o           : final remainder non-zero
//   div_zero_o         : divisor was zero
module lagarto_fp_mantissa_div
  import lagarto_fpu_pkg::*;
#(
  parameter int MANTISSA = 53
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lock_i,
  input  logic                flush_i,
  input  logic                op_valid_i,
  output logic                ready_o,
  input  logic [MANTISSA-1:0] src1_i,
  input  logic [MANTISSA-1:0] src2_i,
  output logic                result_valid_o,
  output logic [MANTISSA+1:0] result_data_o,
  output logic                sticky_o,
  output logic                div_zero_o
);

  localparam int ITERS = div_iter_count(MANTISSA);
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

  div_state_t          state_q;
  logic [MANTISSA-1:0] b_q;
  logic [MANTISSA:0]   rem_q;
  logic [MANTISSA+1:0] q_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dz_q;

  logic                step_q_bit;
  logic [MANTISSA:0]   step_rem;

  lagarto_fp_div_step #(
    .MANTISSA (MANTISSA)
  ) u_step (
    .rem_i   (rem_q),
    .b_i     (b_q),
    .q_bit_o (step_q_bit),
    .rem_o   (step_rem)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= DIV_IDLE;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else if (!lock_i) begin
      case (state_q)
        DIV_IDLE: begin
          if (op_valid_i) begin
            b_q   <= src2_i;
            cnt_q <= CNT_INIT;
            if (src2_i == '0) begin
              // Divide by zero skips iteration: saturated quotient, clean remainder.
              rem_q   <= '0;
              q_q     <= '1;
              dz_q    <= 1'b1;
              state_q <= DIV_DONE;
            end else begin
              rem_q   <= {1'b0, src1_i};
              q_q     <= '0;
              dz_q    <= 1'b0;
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          q_q   <= {q_q[MANTISSA:0], step_q_bit};
          rem_q <= step_rem;
          // The step at cnt==0 is the last one; the counter never wraps.
          if (cnt_q == '0) begin
            state_q <= DIV_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // Outputs are gated to zero outside DONE.
  always_comb begin
    ready_o        = (state_q == DIV_IDLE) && !lock_i;
    result_valid_o = (state_q == DIV_DONE);
    result_data_o  = result_valid_o ? q_q : '0;
    sticky_o       = result_valid_o && (rem_q != '0);
    div_zero_o     = result_valid_o && dz_q;
  end

  // Operands must be normalized unless the divisor is zero.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (op_valid_i && ready_o && !flush_i) |->
      ((src1_i[MANTISSA-1] && src2_i[MANTISSA-1]) || (src2_i == '0)));

endmodule

// File: tb/tb_lagarto_fp_mantissa_div.sv
module tb_lagarto_fp_mantissa_div;

  typedef struct {
    logic [127:0] q;
    logic         sticky;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // MANTISSA = 4 instance
  logic       lock4 = 0, flush4 = 0, opv4 = 0, rdy4, v4, st4, dz4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [5:0] q4;

  // MANTISSA = 53 instance
  logic        lock53 = 0, flush53 = 0, opv53 = 0, rdy53, v53, st53, dz53;
  logic [52:0] a53 = 0, b53 = 0;
  logic [54:0] q53;

  lagarto_fp_mantissa_div #(.MANTISSA(4)) u_div4 (
    .clk_i (clk), .rst_i (rst), .lock_i (lock4), .flush_i (flush4),
    .op_valid_i (opv4), .ready_o (rdy4), .src1_i (a4), .src2_i (b4),
    .result_valid_o (v4), .result_data_o (q4), .sticky_o (st4), .div_zero_o (dz4)
  );

  lagarto_fp_mantissa_div #(.MANTISSA(53)) u_div53 (
    .clk_i (clk), .rst_i (rst), .lock_i (lock53), .flush_i (flush53),
    .op_valid_i (opv53), .ready_o (rdy53), .src1_i (a53), .src2_i (b53),
    .result_valid_o (v53), .result_data_o (q53), .sticky_o (st53), .div_zero_o (dz53)
  );

  exp_t sb4[$];
  exp_t sb53[$];
  int   results4  = 0;
  int   results53 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input int m, input logic [127:0] a, input logic [127:0] b);
    exp_t e;
    logic [127:0] num;
    num = a << (m + 1);
    if (b == 0) begin
      e.q      = (128'd1 << (m + 2)) - 128'd1;
      e.sticky = 1'b0;
      e.dz     = 1'b1;
      e.lat    = 1;
    end else begin
      e.q      = num / b;
      e.sticky = (num % b) != 0;
      e.dz     = 1'b0;
      e.lat    = m + 3;
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitors: compare on the first cycle of each result.
  logic v4_prev = 0, v53_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) v4_prev = 0;
    else begin
      if (v4 && !v4_prev) begin
        results4++;
        check("m4_result_expected", 128'(sb4.size() != 0), 128'd1);
        if (sb4.size() != 0) begin
          e = sb4.pop_front();
          check("m4_q", 128'(q4), e.q);
          check("m4_sticky", 128'(st4), 128'(e.sticky));
          check("m4_div_zero", 128'(dz4), 128'(e.dz));
          check("m4_latency", 128'(cyc - e.acc + 1), 128'(e.lat));
        end
      end
      v4_prev = v4;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) v53_prev = 0;
    else begin
      if (v53 && !v53_prev) begin
        results53++;
        check("m53_result_expected", 128'(sb53.size() != 0), 128'd1);
        if (sb53.size() != 0) begin
          e = sb53.pop_front();
          check("m53_q", 128'(q53), e.q);
          check("m53_sticky", 128'(st53), 128'(e.sticky));
          check("m53_div_zero", 128'(dz53), 128'(e.dz));
          check("m53_latency", 128'(cyc - e.acc + 1), 128'(e.lat));
        end
      end
      v53_prev = v53;
    end
  end

  // Issue one request; returns at the negedge after the acceptance edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input int extra, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!rdy4 && n < 200) begin @(negedge clk); n++; end
    check("m4_ready_before_issue", 128'(rdy4), 128'd1);
    opv4 = 1; a4 = a; b4 = b;
    if (push) begin
      e = model(4, 128'(a), 128'(b));
      e.lat += extra;
      e.acc = cyc + 1;
      sb4.push_back(e);
    end
    @(negedge clk);
    opv4 = 0;
  endtask

  task automatic issue53(input logic [52:0] a, input logic [52:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!rdy53 && n < 200) begin @(negedge clk); n++; end
    check("m53_ready_before_issue", 128'(rdy53), 128'd1);
    opv53 = 1; a53 = a; b53 = b;
    e = model(53, 128'(a), 128'(b));
    e.acc = cyc + 1;
    sb53.push_back(e);
    @(negedge clk);
    opv53 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb4.size() != 0 || sb53.size() != 0) && n < 500) begin @(negedge clk); n++; end
    check("drain_timeout", 128'(sb4.size() + sb53.size()), 128'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [52:0] ra, rb;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_ready", 128'(rdy4), 128'd1);
    check("rst_valid", 128'(v4), 128'd0);
    check("rst_data", 128'(q4), 128'd0);
    check("rst_sticky", 128'(st4), 128'd0);
    check("rst_div_zero", 128'(dz4), 128'd0);
    check("rst_ready53", 128'(rdy53), 128'd1);
    check("rst_valid53", 128'(v53), 128'd0);

    // Directed MANTISSA=4 cases.
    issue4(4'd8,  4'd8,  0, 1'b1);
    issue4(4'd8,  4'd12, 0, 1'b1);
    issue4(4'd12, 4'd8,  0, 1'b1);
    issue4(4'd8,  4'd0,  0, 1'b1);
    drain();

    // Lock for three cycles mid-iteration.
    issue4(4'd8, 4'd12, 3, 1'b1);
    repeat (2) @(negedge clk);
    lock4 = 1;
    repeat (3) begin
      check("lock_ready_low", 128'(rdy4), 128'd0);
      @(negedge clk);
    end
    lock4 = 0;
    drain();

    // Flush mid-iteration: nothing comes out.
    r0 = results4;
    issue4(4'd12, 4'd12, 0, 1'b0);
    repeat (2) @(negedge clk);
    flush4 = 1;
    @(negedge clk);
    flush4 = 0;
    check("flush_ready", 128'(rdy4), 128'd1);
    check("flush_valid", 128'(v4), 128'd0);
    repeat (12) @(negedge clk);
    check("flush_no_result", 128'(results4 - r0), 128'd0);

    // Requests during BUSY are ignored.
    r0 = results4;
    issue4(4'd8, 4'd8, 0, 1'b1);
    repeat (2) begin
      opv4 = 1; a4 = 4'd12; b4 = 4'd8;
      check("busy_ready_low", 128'(rdy4), 128'd0);
      @(negedge clk);
      opv4 = 0;
      @(negedge clk);
    end
    drain();
    check("busy_one_result", 128'(results4 - r0), 128'd1);

    // Directed MANTISSA=53 cases.
    issue53(53'd1 << 52, 53'd3 << 51);
    issue53(53'd1 << 52, 53'd1 << 52);
    drain();

    // Randomized operands for both widths.
    for (int i = 0; i < 16; i++) begin
      ra = {1'b1, 52'({$urandom, $urandom})};
      rb = ($urandom_range(0, 7) == 0) ? 53'd0 : {1'b1, 52'({$urandom, $urandom})};
      issue53(ra, rb);
    end
    for (int i = 0; i < 12; i++) begin
      issue4({1'b1, 3'($urandom)},
             ($urandom_range(0, 5) == 0) ? 4'd0 : {1'b1, 3'($urandom)}, 0, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
